// File: rtl/fb_arbiter.sv
// -----------------------------------------------------------------------------
// fb_arbiter
//
// Shares one synchronous single-port pixel RAM between the VGA display
// prefetch path and the mask engine.
//
// Arbitration
//   Display has fixed priority over the mask engine. A starvation counter forces
//   a mask grant after STARVE_MAX consecutive denied mask cycles. An urgent
//   display request (line buffer below its low watermark) beats everything,
//   including a starved mask and a held mask lock. The mask engine can hold its
//   grant for the following cycle with msk_lock, which makes a read-modify-write
//   pair atomic.
//
// Parameters
//   ADDR_W      pixel address width
//   DATA_W      pixel width (4/4/4 RGB)
//   STARVE_MAX  denied mask cycles before a forced mask grant (1..255)
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   disp_req/urgent/addr            display read request
//   disp_gnt                        display handshake accepted this cycle
//   disp_rvalid/rdata               display read return
//   msk_req/we/lock/addr/wdata      mask access request
//   msk_gnt                         mask handshake accepted this cycle
//   msk_rvalid/rdata                mask read return
//   mem_en/we/addr/wdata            registered RAM command
//   mem_rdata                       RAM read data, one cycle after a read
//
// Latency: handshake in cycle N drives the RAM in N+1, read data and rvalid
// appear in N+2. One access per cycle.
// -----------------------------------------------------------------------------
module fb_arbiter #(
  parameter int ADDR_W     = 17,
  parameter int DATA_W     = 12,
  parameter int STARVE_MAX = 15
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              disp_req,
  input  logic              disp_urgent,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_gnt,
  output logic              disp_rvalid,
  output logic [DATA_W-1:0] disp_rdata,

  input  logic              msk_req,
  input  logic              msk_we,
  input  logic              msk_lock,
  input  logic [ADDR_W-1:0] msk_addr,
  input  logic [DATA_W-1:0] msk_wdata,
  output logic              msk_gnt,
  output logic              msk_rvalid,
  output logic [DATA_W-1:0] msk_rdata,

  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic {
    ST_NORMAL = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

  state_t     state;
  logic [7:0] starve_cnt;

  logic disp_gnt_c;
  logic msk_gnt_c;
  logic disp_urgent_req;
  logic msk_starved;
  logic any_gnt;

  // Read-return tags: valid plus owner (1 = mask, 0 = display).
  logic tag1_valid;
  logic tag1_owner;
  logic tag2_valid;
  logic tag2_owner;

  assign disp_urgent_req = disp_req & disp_urgent;
  assign msk_starved     = msk_req & (starve_cnt == STARVE_LIM);

  // Grant decision, combinational from the requests and registered state.
  // A held lock keeps the mask granted unless the display is urgent; in every
  // other case the normal priority order applies. Grants are suppressed while
  // reset is asserted so that all outputs read 0 during reset.
  always_comb begin
    disp_gnt_c = 1'b0;
    msk_gnt_c  = 1'b0;
    if (rst_n) begin
      if ((state == ST_LOCKED) && msk_req && !disp_urgent_req) begin
        msk_gnt_c = 1'b1;
      end else if (disp_urgent_req) begin
        disp_gnt_c = 1'b1;
      end else if (msk_starved) begin
        msk_gnt_c = 1'b1;
      end else if (disp_req) begin
        disp_gnt_c = 1'b1;
      end else if (msk_req) begin
        msk_gnt_c = 1'b1;
      end
    end
  end

  assign disp_gnt = disp_gnt_c;
  assign msk_gnt  = msk_gnt_c;
  assign any_gnt  = disp_gnt_c | msk_gnt_c;

  // Lock FSM and starvation counter. The lock is (re)entered only by a mask
  // transfer that asks for it, so any other cycle, including an urgent display
  // preemption, drops back to NORMAL. The counter saturates so that an urgent
  // display can hold a starved mask off indefinitely without wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_NORMAL;
      starve_cnt <= 8'd0;
    end else begin
      if (msk_gnt_c && msk_lock) begin
        state <= ST_LOCKED;
      end else begin
        state <= ST_NORMAL;
      end

      if (msk_req && !msk_gnt_c) begin
        if (starve_cnt != STARVE_LIM) begin
          starve_cnt <= starve_cnt + 8'd1;
        end
      end else begin
        starve_cnt <= 8'd0;
      end
    end
  end

  // Registered RAM command. Address, write enable and write data hold their
  // last values in idle cycles; a display read leaves the write data untouched
  // because it is never written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_en <= any_gnt;
      if (msk_gnt_c) begin
        mem_we    <= msk_we;
        mem_addr  <= msk_addr;
        mem_wdata <= msk_wdata;
      end else if (disp_gnt_c) begin
        mem_we   <= 1'b0;
        mem_addr <= disp_addr;
      end
    end
  end

  // Two-stage read-return tag pipeline. Stage 1 travels with the RAM command,
  // stage 2 lines up with mem_rdata. Reset clears both, so reads in flight at
  // reset never return.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag1_valid <= 1'b0;
      tag1_owner <= 1'b0;
      tag2_valid <= 1'b0;
      tag2_owner <= 1'b0;
    end else begin
      tag1_valid <= disp_gnt_c | (msk_gnt_c & ~msk_we);
      tag1_owner <= msk_gnt_c;
      tag2_valid <= tag1_valid;
      tag2_owner <= tag1_owner;
    end
  end

  assign disp_rvalid = tag2_valid & ~tag2_owner;
  assign msk_rvalid  = tag2_valid &  tag2_owner;
  assign disp_rdata  = {DATA_W{disp_rvalid}} & mem_rdata;
  assign msk_rdata   = {DATA_W{msk_rvalid}}  & mem_rdata;

endmodule

// File: tb/tb_fb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fb_arbiter
//
// Drives fb_arbiter with directed scenarios and random traffic, attached to a
// small synchronous RAM. A transaction-level reference model predicts grants,
// the RAM command one cycle later, and the routed read data two cycles later.
// -----------------------------------------------------------------------------
module tb_fb_arbiter;

  localparam int AW   = 17;
  localparam int DW   = 12;
  localparam int SMAX = 15;
  localparam int RAMD = 1024;

  logic          clk;
  logic          rst_n;
  logic          disp_req;
  logic          disp_urgent;
  logic [AW-1:0] disp_addr;
  logic          disp_gnt;
  logic          disp_rvalid;
  logic [DW-1:0] disp_rdata;
  logic          msk_req;
  logic          msk_we;
  logic          msk_lock;
  logic [AW-1:0] msk_addr;
  logic [DW-1:0] msk_wdata;
  logic          msk_gnt;
  logic          msk_rvalid;
  logic [DW-1:0] msk_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  fb_arbiter #(
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .STARVE_MAX(SMAX)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .disp_req   (disp_req),
    .disp_urgent(disp_urgent),
    .disp_addr  (disp_addr),
    .disp_gnt   (disp_gnt),
    .disp_rvalid(disp_rvalid),
    .disp_rdata (disp_rdata),
    .msk_req    (msk_req),
    .msk_we     (msk_we),
    .msk_lock   (msk_lock),
    .msk_addr   (msk_addr),
    .msk_wdata  (msk_wdata),
    .msk_gnt    (msk_gnt),
    .msk_rvalid (msk_rvalid),
    .msk_rdata  (msk_rdata),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_pat(input int a);
    return DW'((a * 37) ^ (a >> 3) ^ 'h5a5);
  endfunction

  // Synchronous pixel RAM seen by the DUT; only the low address bits are used.
  logic [DW-1:0] ram [RAMD];

  initial begin
    for (int i = 0; i < RAMD; i++) ram[i] = init_pat(i);
    mem_rdata = '0;
  end

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr[9:0]] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr[9:0]];
    end
  end

  // Reference model state: what the pixel store should contain, the lock and
  // starvation bookkeeping, the expected RAM command and pending read returns.
  typedef struct {
    int            due;
    logic          owner;
    logic [DW-1:0] data;
  } ret_t;

  logic [DW-1:0] shadow [RAMD];
  ret_t          pending[$];
  int            cyc;
  bit            m_locked;
  int            m_starve;
  logic          exp_en;
  logic          exp_we;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_wdata;
  logic          exp_dg;
  logic          exp_mg;

  int n_checks;
  int n_errors;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)",
               tag, actual, expected, cyc);
    end
  endtask

  task automatic flushModel();
    pending.delete();
    m_locked  = 1'b0;
    m_starve  = 0;
    exp_en    = 1'b0;
    exp_we    = 1'b0;
    exp_addr  = '0;
    exp_wdata = '0;
  endtask

  // Outputs that settle from registers: RAM command and read returns.
  task automatic checkRegistered();
    logic          rv_d;
    logic          rv_m;
    logic [DW-1:0] rd;
    rv_d = 1'b0;
    rv_m = 1'b0;
    rd   = '0;
    if (pending.size() > 0 && pending[0].due == cyc) begin
      if (pending[0].owner) rv_m = 1'b1;
      else                  rv_d = 1'b1;
      rd = pending[0].data;
      void'(pending.pop_front());
    end
    checkOutput("mem_en",      mem_en,      exp_en);
    checkOutput("mem_we",      mem_we,      exp_we);
    checkOutput("mem_addr",    mem_addr,    exp_addr);
    checkOutput("mem_wdata",   mem_wdata,   exp_wdata);
    checkOutput("disp_rvalid", disp_rvalid, rv_d);
    checkOutput("disp_rdata",  disp_rdata,  rv_d ? rd : '0);
    checkOutput("msk_rvalid",  msk_rvalid,  rv_m);
    checkOutput("msk_rdata",   msk_rdata,   rv_m ? rd : '0);
  endtask

  // One clock cycle: check registered outputs, apply the requests, check the
  // grants against the model, then advance the model past the next edge.
  task automatic applyStimulus(input logic dreq, input logic durg,
                               input logic [AW-1:0] daddr,
                               input logic mreq, input logic mwe,
                               input logic mlock, input logic [AW-1:0] maddr,
                               input logic [DW-1:0] mwdata);
    bit            urg;
    logic [AW-1:0] a;
    @(negedge clk);
    checkRegistered();
    disp_req    = dreq;
    disp_urgent = durg;
    disp_addr   = daddr;
    msk_req     = mreq;
    msk_we      = mwe;
    msk_lock    = mlock;
    msk_addr    = maddr;
    msk_wdata   = mwdata;
    #1;
    urg    = dreq && durg;
    exp_dg = 1'b0;
    exp_mg = 1'b0;
    if (m_locked && mreq && !urg)          exp_mg = 1'b1;
    else if (urg)                          exp_dg = 1'b1;
    else if (mreq && m_starve == SMAX)     exp_mg = 1'b1;
    else if (dreq)                         exp_dg = 1'b1;
    else if (mreq)                         exp_mg = 1'b1;
    checkOutput("disp_gnt", disp_gnt, exp_dg);
    checkOutput("msk_gnt",  msk_gnt,  exp_mg);

    exp_en = exp_dg || exp_mg;
    if (exp_en) begin
      a        = exp_mg ? maddr : daddr;
      exp_addr = a;
      exp_we   = exp_mg && mwe;
      if (exp_mg) exp_wdata = mwdata;
      if (exp_we) shadow[a[9:0]] = mwdata;
      else        pending.push_back('{cyc + 2, exp_mg, shadow[a[9:0]]});
    end
    m_locked = exp_mg && mlock;
    if (mreq && !exp_mg) m_starve = (m_starve < SMAX) ? m_starve + 1 : SMAX;
    else                 m_starve = 0;
    cyc++;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic checkAllZero();
    checkOutput("rst_disp_gnt",    disp_gnt,    1'b0);
    checkOutput("rst_msk_gnt",     msk_gnt,     1'b0);
    checkOutput("rst_mem_en",      mem_en,      1'b0);
    checkOutput("rst_mem_we",      mem_we,      1'b0);
    checkOutput("rst_mem_addr",    mem_addr,    '0);
    checkOutput("rst_mem_wdata",   mem_wdata,   '0);
    checkOutput("rst_disp_rvalid", disp_rvalid, 1'b0);
    checkOutput("rst_disp_rdata",  disp_rdata,  '0);
    checkOutput("rst_msk_rvalid",  msk_rvalid,  1'b0);
    checkOutput("rst_msk_rdata",   msk_rdata,   '0);
  endtask

  // Hold reset with both requesters asking; release with requests idle.
  task automatic doReset();
    @(negedge clk);
    rst_n       = 1'b0;
    disp_req    = 1'b1;
    disp_urgent = 1'b0;
    msk_req     = 1'b1;
    msk_we      = 1'b0;
    msk_lock    = 1'b1;
    #1;
    checkAllZero();
    repeat (3) begin
      @(negedge clk);
      checkAllZero();
    end
    disp_req = 1'b0;
    msk_req  = 1'b0;
    msk_lock = 1'b0;
    rst_n    = 1'b1;
    flushModel();
  endtask

  // Scenario sequence: reset, directed arbitration cases, random traffic with
  // a mid-run reset, then drain and summary.
  initial begin
    int first_gnt;
    int msk_cnt;
    logic g1;
    logic g2;
    logic g3;

    n_checks    = 0;
    n_errors    = 0;
    cyc         = 0;
    rst_n       = 1'b0;
    disp_req    = 1'b0;
    disp_urgent = 1'b0;
    disp_addr   = '0;
    msk_req     = 1'b0;
    msk_we      = 1'b0;
    msk_lock    = 1'b0;
    msk_addr    = '0;
    msk_wdata   = '0;
    for (int i = 0; i < RAMD; i++) shadow[i] = init_pat(i);
    flushModel();

    doReset();
    $display("[TB] reset then display read of 0x00005");
    applyStimulus(1'b1, 1'b0, AW'(5), 1'b0, 1'b0, 1'b0, '0, '0);
    idleCycle();
    checkOutput("first_read_mem_en", mem_en, 1'b1);
    idleCycle();
    checkOutput("first_read_rvalid", disp_rvalid, 1'b1);
    idleCycle();

    $display("[TB] starvation");
    first_gnt = 0;
    for (int i = 1; i <= 17; i++) begin
      applyStimulus(1'b1, 1'b0, AW'(i), 1'b1, 1'b0, 1'b0, AW'(40 + i), '0);
      if (msk_gnt && first_gnt == 0) first_gnt = i;
      if (i == 17) checkOutput("starve_disp_after", disp_gnt, 1'b1);
    end
    checkOutput("starve_first_msk_gnt", first_gnt, 16);
    idleCycle();

    $display("[TB] urgent override");
    msk_cnt = 0;
    for (int i = 0; i < 24; i++) begin
      applyStimulus(1'b1, 1'b1, AW'(i), 1'b1, 1'b0, 1'b0, AW'(60), '0);
      if (msk_gnt) msk_cnt++;
    end
    checkOutput("urgent_msk_never", msk_cnt, 0);
    applyStimulus(1'b1, 1'b0, AW'(7), 1'b1, 1'b0, 1'b0, AW'(60), '0);
    checkOutput("urgent_drop_msk_gnt", msk_gnt, 1'b1);
    idleCycle();

    $display("[TB] read-modify-write lock");
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b1, AW'('h100), '0);
    g1 = msk_gnt;
    applyStimulus(1'b1, 1'b0, AW'(9), 1'b1, 1'b1, 1'b0, AW'('h100), DW'('habc));
    g2 = msk_gnt;
    applyStimulus(1'b1, 1'b0, AW'(9), 1'b0, 1'b0, 1'b0, '0, '0);
    g3 = disp_gnt;
    checkOutput("rmw_read_gnt",  g1, 1'b1);
    checkOutput("rmw_write_gnt", g2, 1'b1);
    checkOutput("rmw_disp_next", g3, 1'b1);
    idleCycle();
    idleCycle();
    checkOutput("rmw_ram", ram[10'h100], DW'('habc));
    applyStimulus(1'b1, 1'b0, AW'('h100), 1'b0, 1'b0, 1'b0, '0, '0);
    idleCycle();

    $display("[TB] lock preemption");
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b1, AW'(20), '0);
    applyStimulus(1'b1, 1'b1, AW'(21), 1'b1, 1'b1, 1'b1, AW'(20), DW'(3));
    checkOutput("preempt_disp_gnt", disp_gnt, 1'b1);
    applyStimulus(1'b1, 1'b0, AW'(22), 1'b1, 1'b1, 1'b0, AW'(20), DW'(3));
    checkOutput("preempt_rearbitrate", msk_gnt, 1'b0);
    idleCycle();

    $display("[TB] interleaved reads");
    for (int i = 0; i < 12; i++) begin
      if (i % 2 == 0) applyStimulus(1'b1, 1'b0, AW'(200 + i), 1'b0, 1'b0, 1'b0, '0, '0);
      else            applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0, AW'(300 + i), '0);
    end

    $display("[TB] random traffic");
    for (int i = 0; i < 3000; i++) begin
      logic dr;
      logic du;
      logic mr;
      dr = ($urandom_range(0, 99) < 60);
      du = dr && ($urandom_range(0, 99) < 15);
      mr = ($urandom_range(0, 99) < 70);
      applyStimulus(dr, du, AW'($urandom_range(0, 63)), mr,
                    1'($urandom_range(0, 1)), ($urandom_range(0, 99) < 35),
                    AW'($urandom_range(0, 63)), DW'($urandom));
      if (i == 1500) doReset();
    end

    repeat (3) idleCycle();
    checkOutput("drain_pending", pending.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
